spi_xfer_core: RTL and testbench
================================

# spi_xfer_core

Single-clock SPI master core for the host-controlled SPI flash bridge. It divides the system clock into a programmable-rate SPI clock and runs a chip-select-framed transfer of up to 64 bits. Each transfer shifts a host-supplied word out MSB-first on `spi_dq0` and captures `spi_dq1` into a 64-bit receive register. It sits between the host wire/trigger endpoints and the quad-SPI flash pins, which are used in single-bit mode.

## Interface
- No parameters; transfer width is fixed at 64 bits.
- `CLK` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-`CLK` start pulse.
- `tx_data` in 64: word to transmit; sampled when the transfer starts.
- `xfer_len` in 32: bit count N, sampled when the transfer starts.
- `clk_ratio` in 32: SCK half-period minus one, in `CLK` cycles.
- `rx_data` out 64: receive shift register.
- `busy` out 1: internal shift-enable `en`.
- `spi_c` out 1: SPI clock (SCK).
- `spi_s` out 1: chip select, active low.
- `spi_dq0` out 1: MOSI.
- `spi_dq1` in 1: MISO.
- `spi_w_dq2` out 1: constant 1.
- `spi_hold_dq3` out 1: constant 1.
- `led` out 8: equals `tx_data[63:56]`.
- `status` out 5: `{spi_dq1, en, spi_s, spi_c, spi_dq0}`.

## Operation
- **Divider.** Uses a 32-bit `div` counter.
  - When `div==0`: `div<=clk_ratio` and `spi_c` toggles.
  - Otherwise `div<=div-1`.
  - SCK half-period is `clk_ratio+1` cycles.
  - A new `clk_ratio` takes effect at the next reload.
- **Ticks.**
  - A *rise tick* is a cycle with `div==0 && spi_c==0`.
  - A *fall tick* is a cycle with `div==0 && spi_c==1`.
  - All SPI state below updates only on ticks, in the same `CLK` edge as the SCK toggle.
- **Start capture.** A `start` pulse sets `pending`. The next rise tick consumes it (this is rise tick R0).
- **Rise tick, in priority order:**
  1. If `pending`:
     - `pending<=0`, `spi_s<=0`, `cnt<=xfer_len`;
     - `rx_data<=0`, `tx<=tx_data`;
     - `en` is unchanged.
  2. Else if `cnt==0`: `en<=0`, `spi_s<=1`.
  3. Else:
     - `cnt<=cnt-1`;
     - if `spi_s==0`, `en<=1`;
     - if the old `en==1`, `rx_data<={rx_data[62:0], spi_dq1}`.
- **Fall tick.** If `en`: `tx<={tx[62:0],1'b0}`.
- **MOSI.** `spi_dq0 = tx[63]`, combinational from the register.
- **Frame length.**
  - Over a frame of length N, `spi_s` is low from R0 through R(N+1).
  - `en` is high from R1 through R(N+1).
  - MOSI bits `tx_data[63..64-N]` are valid at R1..RN.
  - `rx` samples at R2..R(N+1), N samples total.
- **Boundaries.**
  - N=0: `spi_s` goes low at R0 and high at R1; no shifts occur.
  - N>64: the transmitter shifts out zeros after 64 bits; `rx_data` holds the last 64 samples.
- **Restart.** `start` during a busy frame restarts the frame at the next rise tick: `cnt` is reloaded and the registers are reloaded/cleared.
- **Reset.** `rst` at any time, including mid-frame, forces:
  - `div=0`, `spi_c=0`, `spi_s=1`, `en=0`, `cnt=0`, `pending=0`;
  - `tx=0`, `rx_data=0`, so `spi_dq0=0`.

## Timing
- Latency from `start` to `spi_s` falling: wait for the next rise tick, at most 2·(`clk_ratio`+1) `CLK` cycles. `spi_s` falls on the same edge as SCK rising.
- `rx_data` bits update on SCK rising edges; `spi_dq0` changes on SCK falling edges.
- The transfer is complete when `spi_s` returns to 1. This happens at R(N+1), (N+1) SCK periods after R0.
- `clk_ratio=0` gives SCK = `CLK`/2.
- All outputs are registered except `spi_dq0`, `led` and `status`, which are wired from registers and inputs.

## Test plan
- **Reset.**
  - Stimulus: assert `rst` mid-frame.
  - Response: next cycle `spi_s=1`, `spi_c=0`, `en=0`, `rx_data=0`, `spi_dq0=0`.
- **Divider.**
  - Stimulus: `clk_ratio=3`, idle.
  - Response: `spi_c` toggles every 4 `CLK` cycles (period 8).
  - Stimulus: change to 0.
  - Response: period becomes 2 after the next reload.
- **TX.**
  - Stimulus: `clk_ratio=1`, `xfer_len=8`, `tx_data=64'hA5<<56`.
  - Response: `spi_dq0` sampled at R1..R8 gives 1,0,1,0,0,1,0,1; `spi_s` is low for exactly 9 SCK periods.
- **RX.**
  - Stimulus: `spi_dq1=1`, `xfer_len=8`.
  - Response: final `rx_data=64'hFF`.
  - Stimulus: `xfer_len=64` with `spi_dq1` alternating per rise tick starting at 1.
  - Response: `rx_data=64'hAAAA_AAAA_AAAA_AAAA`.
- **Zero length.**
  - Stimulus: `xfer_len=0`.
  - Response: `spi_s` low for one SCK period, `en` never asserted, `rx_data=0`.
- **Restart.**
  - Stimulus: second `start` at bit 3 of a 16-bit frame.
  - Response: `rx_data` cleared, `tx` reloaded, frame runs a full 16 bits from the new R0.

Source files
------------

// File: rtl/spi_xfer_core.sv
// Single-clock SPI master: programmable SCK divider and a chip-select framed
// transfer of up to 64 bits, MSB first on dq0, capturing dq1 into rx_data.
module spi_xfer_core (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] tx_data,
    input  logic [31:0] xfer_len,
    input  logic [31:0] clk_ratio,
    output logic [63:0] rx_data,
    output logic        busy,
    output logic        spi_c,
    output logic        spi_s,
    output logic        spi_dq0,
    input  logic        spi_dq1,
    output logic        spi_w_dq2,
    output logic        spi_hold_dq3,
    output logic [7:0]  led,
    output logic [4:0]  status
);

    logic [31:0] div, div_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [63:0] tx, tx_nxt;
    logic [63:0] rx_nxt;
    logic        spi_c_nxt;
    logic        spi_s_nxt;
    logic        en, en_nxt;
    logic        pending, pending_nxt;
    logic        tick;
    logic        rise_tick;
    logic        fall_tick;

    assign tick      = (div == 32'd0);
    assign rise_tick = tick && !spi_c;
    assign fall_tick = tick && spi_c;

    // NOTE: every next-state signal gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        div_nxt     = div;
        spi_c_nxt   = spi_c;
        spi_s_nxt   = spi_s;
        en_nxt      = en;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        tx_nxt      = tx;
        rx_nxt      = rx_data;

        if (tick) begin
            div_nxt   = clk_ratio;
            spi_c_nxt = ~spi_c;
        end else begin
            div_nxt = div - 32'd1;
        end

        if (rise_tick) begin
            if (pending) begin
                pending_nxt = 1'b0;
                spi_s_nxt   = 1'b0;
                cnt_nxt     = xfer_len;
                rx_nxt      = 64'd0;
                tx_nxt      = tx_data;
            end else begin
                if (cnt == 32'd0) begin
                    en_nxt    = 1'b0;
                    spi_s_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                    if (!spi_s) en_nxt = 1'b1;
                end
                // Sampling also on the closing rise tick yields N samples (R2..R(N+1)).
                if (en) rx_nxt = {rx_data[62:0], spi_dq1};
            end
        end

        if (fall_tick && en) tx_nxt = {tx[62:0], 1'b0};

        // A start arriving on the consuming rise tick is kept for the next one.
        if (start) pending_nxt = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            div     <= 32'd0;
            spi_c   <= 1'b0;
            spi_s   <= 1'b1;
            en      <= 1'b0;
            cnt     <= 32'd0;
            pending <= 1'b0;
            tx      <= 64'd0;
            rx_data <= 64'd0;
        end else begin
            div     <= div_nxt;
            spi_c   <= spi_c_nxt;
            spi_s   <= spi_s_nxt;
            en      <= en_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            tx      <= tx_nxt;
            rx_data <= rx_nxt;
        end
    end

    assign busy         = en;
    assign spi_dq0      = tx[63];
    assign spi_w_dq2    = 1'b1;
    assign spi_hold_dq3 = 1'b1;
    assign led          = tx_data[63:56];
    assign status       = {spi_dq1, en, spi_s, spi_c, spi_dq0};

endmodule

// File: tb/tb_spi_xfer_core.sv
// Directed bench for spi_xfer_core: reset, divider, TX/RX framing, zero
// length, restart and mid-frame reset, all against hand-computed values.
module tb_spi_xfer_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] tx_data = 64'd0;
    logic [31:0] xfer_len = 32'd0;
    logic [31:0] clk_ratio = 32'd1;
    logic        spi_dq1 = 1'b0;
    logic [63:0] rx_data;
    logic        busy, spi_c, spi_s, spi_dq0, spi_w_dq2, spi_hold_dq3;
    logic [7:0]  led;
    logic [4:0]  status;

    int n_checks = 0;
    int n_errors = 0;

    logic c_prev = 1'b0;
    logic rise = 1'b0;
    logic tog = 1'b0;
    logic busy_seen = 1'b0;

    spi_xfer_core dut (
        .CLK          (clk),
        .rst          (rst),
        .start        (start),
        .tx_data      (tx_data),
        .xfer_len     (xfer_len),
        .clk_ratio    (clk_ratio),
        .rx_data      (rx_data),
        .busy         (busy),
        .spi_c        (spi_c),
        .spi_s        (spi_s),
        .spi_dq0      (spi_dq0),
        .spi_dq1      (spi_dq1),
        .spi_w_dq2    (spi_w_dq2),
        .spi_hold_dq3 (spi_hold_dq3),
        .led          (led),
        .status       (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling CLK edge and classify what SCK did.
    task automatic step();
        @(negedge clk);
        rise      = spi_c && !c_prev;
        tog       = (spi_c != c_prev);
        c_prev    = spi_c;
        busy_seen = busy_seen | busy;
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!rise && n < 100);
        if (!rise) check({tag, "_timeout"}, 64'(rise), 64'd1);
    endtask

    task automatic wait_toggle(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tog && n < 100);
        if (!tog) check({tag, "_timeout"}, 64'(tog), 64'd1);
    endtask

    task automatic measure(input string tag, output int n);
        wait_toggle(tag);
        n = 0;
        do begin
            step();
            n++;
        end while (!tog && n < 100);
    endtask

    // Pulse start for one CLK and return just after rise tick R0.
    task automatic start_xfer(input logic [31:0] len, input logic [63:0] data);
        xfer_len = len;
        tx_data  = data;
        start    = 1'b1;
        step();
        start = 1'b0;
        wait_rise("r0");
    endtask

    initial begin
        int         n;
        logic [7:0] pat;

        repeat (3) step();
        check("rst_spi_s", 64'(spi_s), 64'd1);
        check("rst_spi_c", 64'(spi_c), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rx", rx_data, 64'd0);
        check("rst_dq0", 64'(spi_dq0), 64'd0);
        check("rst_wp_hold", {62'd0, spi_w_dq2, spi_hold_dq3}, 64'd3);
        rst = 1'b0;

        // Divider: half-period is clk_ratio+1 CLK cycles.
        clk_ratio = 32'd3;
        measure("div3a", n);
        check("div3_half_a", 64'(n), 64'd4);
        measure("div3b", n);
        check("div3_half_b", 64'(n), 64'd4);
        clk_ratio = 32'd0;
        measure("div0a", n);
        check("div0_half_a", 64'(n), 64'd1);
        measure("div0b", n);
        check("div0_half_b", 64'(n), 64'd1);

        // TX: A5 shifted out MSB first, frame of 9 SCK periods.
        clk_ratio = 32'd1;
        pat = 8'hA5;
        start_xfer(32'd8, 64'hA500_0000_0000_0000);
        check("tx_r0_spi_s", 64'(spi_s), 64'd0);
        check("tx_led", 64'(led), 64'hA5);
        for (int k = 1; k <= 8; k++) begin
            wait_rise("tx_bit");
            check($sformatf("tx_bit%0d", k), 64'(spi_dq0), 64'(pat[8-k]));
            check($sformatf("tx_spi_s_r%0d", k), 64'(spi_s), 64'd0);
            if (k == 1) check("tx_busy_r1", 64'(busy), 64'd1);
        end
        wait_rise("tx_end");
        check("tx_end_spi_s", 64'(spi_s), 64'd1);
        check("tx_end_busy", 64'(busy), 64'd0);

        // RX: constant one over 8 bits.
        spi_dq1 = 1'b1;
        start_xfer(32'd8, 64'd0);
        for (int k = 1; k <= 9; k++) wait_rise("rx8");
        check("rx8_spi_s", 64'(spi_s), 64'd1);
        check("rx8_data", rx_data, 64'hFF);

        // RX: 64 bits alternating per rise tick, first sample (R2) is 1.
        start_xfer(32'd64, 64'd0);
        for (int k = 1; k <= 65; k++) begin
            wait_rise("rx64");
            spi_dq1 = k[0];
        end
        check("rx64_spi_s", 64'(spi_s), 64'd1);
        check("rx64_data", rx_data, 64'hAAAA_AAAA_AAAA_AAAA);

        // Zero length: one SCK period of chip select, no enable.
        spi_dq1   = 1'b1;
        busy_seen = 1'b0;
        start_xfer(32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("z_r0_spi_s", 64'(spi_s), 64'd0);
        wait_rise("z_r1");
        check("z_r1_spi_s", 64'(spi_s), 64'd1);
        check("z_busy_seen", 64'(busy_seen), 64'd0);
        check("z_rx", rx_data, 64'd0);

        // Restart at bit 3 of a 16-bit frame.
        start_xfer(32'd16, 64'd0);
        for (int k = 1; k <= 3; k++) wait_rise("rs_pre");
        check("rs_pre_rx", rx_data, 64'h3);
        check("rs_pre_dq0", 64'(spi_dq0), 64'd0);
        start_xfer(32'd16, 64'hC000_0000_0000_0000);
        check("rs_r0_rx", rx_data, 64'd0);
        check("rs_r0_dq0", 64'(spi_dq0), 64'd1);
        check("rs_r0_spi_s", 64'(spi_s), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            wait_rise("rs_run");
            check($sformatf("rs_spi_s_r%0d", k), 64'(spi_s), 64'd0);
        end
        wait_rise("rs_end");
        check("rs_end_spi_s", 64'(spi_s), 64'd1);

        // Reset in the middle of a frame.
        start_xfer(32'd64, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int k = 1; k <= 3; k++) wait_rise("mr_pre");
        check("mr_pre_rx", rx_data, 64'h3);
        check("mr_pre_dq0", 64'(spi_dq0), 64'd1);
        rst = 1'b1;
        step();
        check("mr_spi_s", 64'(spi_s), 64'd1);
        check("mr_spi_c", 64'(spi_c), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_rx", rx_data, 64'd0);
        check("mr_dq0", 64'(spi_dq0), 64'd0);
        check("mr_status", 64'(status), 64'b10100);
        rst = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
